// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states and the layout of one shadow-scoreboard entry.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    MULT = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       multi;
  } shadow_t;

endpackage

// File: rtl/pipe_fwd_cmp.sv
// Per-operand hazard compare: detects an EX hit and picks the forwarding
// source, with the younger EX result winning over MEM.
module pipe_fwd_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic       use_src,
  input  logic [4:0] src,
  input  logic       ex_valid,
  input  logic       ex_wr,
  input  logic [4:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_wr,
  input  logic [4:0] mem_rd,
  output logic       hit_ex,
  output logic [1:0] fwd_sel
);

  logic live;
  logic hit_mem;

  always_comb begin
    // $0 is hardwired, so it never depends on an in-flight producer
    live    = id_valid && use_src && (src != 5'd0);
    hit_ex  = live && ex_valid && ex_wr && (ex_rd == src);
    hit_mem = live && mem_valid && mem_wr && (mem_rd == src);
    fwd_sel = FWD_RF;
    if (hit_ex) begin
      fwd_sel = FWD_EXMEM;
    end else if (hit_mem) begin
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the ID-EX-MEM-WB pipeline: load-use stall,
// branch flush, registered forwarding selects and multi-cycle EX sequencing.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_multi,
  input  logic       ex_branch_taken,
  output logic       stall_if_id,
  output logic       flush_if_id,
  output logic       bubble_id_ex,
  output logic       hold_id_ex,
  output logic       bubble_ex_mem,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mul_start,
  output logic       ex_busy
);

  // MUL_LAT is legal over 2..16, so the remaining-cycle count fits in 4 bits
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  shadow_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       mul_start_q, mul_start_d;
  logic       ex_busy_q, ex_busy_d;

  shadow_t    id_entry;
  logic       hit_ex_a, hit_ex_b;
  logic [1:0] sel_a, sel_b;
  logic       load_use;
  logic       xfer;

  assign id_entry = '{valid: id_valid, rd: id_rd, wr: id_reg_write,
                      ld: id_mem_read, multi: id_multi};

  pipe_fwd_cmp u_cmp_rs (
    .id_valid  (id_valid),
    .use_src   (id_use_rs),
    .src       (id_rs),
    .ex_valid  (ex_q.valid),
    .ex_wr     (ex_q.wr),
    .ex_rd     (ex_q.rd),
    .mem_valid (mem_q.valid),
    .mem_wr    (mem_q.wr),
    .mem_rd    (mem_q.rd),
    .hit_ex    (hit_ex_a),
    .fwd_sel   (sel_a)
  );

  pipe_fwd_cmp u_cmp_rt (
    .id_valid  (id_valid),
    .use_src   (id_use_rt),
    .src       (id_rt),
    .ex_valid  (ex_q.valid),
    .ex_wr     (ex_q.wr),
    .ex_rd     (ex_q.rd),
    .mem_valid (mem_q.valid),
    .mem_wr    (mem_q.wr),
    .mem_rd    (mem_q.rd),
    .hit_ex    (hit_ex_b),
    .fwd_sel   (sel_b)
  );

  always_comb begin
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    hold_id_ex    = 1'b0;
    bubble_ex_mem = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    fwd_a_d       = fwd_a_q;
    fwd_b_d       = fwd_b_q;
    mul_start_d   = 1'b0;
    ex_busy_d     = ex_busy_q;
    load_use      = (hit_ex_a || hit_ex_b) && ex_q.ld;
    xfer          = 1'b0;

    if ((state_q == MULT) && (cnt_q != 4'd0)) begin
      // Multi op still owns EX: freeze the front end, drain bubbles into MEM
      stall_if_id   = 1'b1;
      hold_id_ex    = 1'b1;
      bubble_ex_mem = 1'b1;
      mem_d         = '0;
      wb_d          = mem_q;
      cnt_d         = cnt_q - 4'd1;
    end else begin
      if (ex_branch_taken) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (load_use) begin
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
      wb_d    = mem_q;
      mem_d   = ex_q;
      xfer    = id_valid && !bubble_id_ex;
      ex_d    = xfer ? id_entry : '0;
      fwd_a_d = bubble_id_ex ? FWD_RF : sel_a;
      fwd_b_d = bubble_id_ex ? FWD_RF : sel_b;
      if (xfer && id_multi) begin
        state_d     = MULT;
        cnt_d       = CNT_INIT;
        mul_start_d = 1'b1;
        ex_busy_d   = 1'b1;
      end else begin
        state_d   = RUN;
        ex_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      mul_start_q <= 1'b0;
      ex_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      mul_start_q <= mul_start_d;
      ex_busy_q   <= ex_busy_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign mul_start = mul_start_q;
  assign ex_busy   = ex_busy_q;

  // WB and some entry fields are tracked for completeness but drive no decision
  logic unused_shadow;
  assign unused_shadow = ^{wb_q, ex_q.multi, mem_q.ld, mem_q.multi};

endmodule
